// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over an 8-bit memory-controller port.
// Non-memory instructions pass straight through to MEM/WB in the same cycle.
module mem_stage #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_flag,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic                  in_we,
  input  logic [4:0]            in_waddr,
  input  logic [31:0]           in_alu,
  input  logic [31:0]           in_rdata2,
  output logic                  mc_req,
  output logic                  mc_we,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  output logic [7:0]            mc_wdata,
  input  logic                  mc_ack,
  input  logic [7:0]            mc_rdata,
  output logic                  wb_we,
  output logic [4:0]            wb_waddr,
  output logic [31:0]           wb_wdata,
  output logic                  stallreq
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic        is_load, is_store, is_mem;
  logic [1:0]  last_idx;
  logic [31:0] byte_addr;
  logic [31:0] wdata_sh;
  logic [31:0] load_val;

  // Decode access kind and index of the final byte (N-1).
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    last_idx = 2'd0;
    if (in_flag) begin
      if (in_opcode == OpLoad) begin
        case (in_funct3)
          3'b000, 3'b100: begin is_load = 1'b1; last_idx = 2'd0; end
          3'b001, 3'b101: begin is_load = 1'b1; last_idx = 2'd1; end
          3'b010:         begin is_load = 1'b1; last_idx = 2'd3; end
          default: ;
        endcase
      end else if (in_opcode == OpStore) begin
        case (in_funct3)
          3'b000:  begin is_store = 1'b1; last_idx = 2'd0; end
          3'b001:  begin is_store = 1'b1; last_idx = 2'd1; end
          3'b010:  begin is_store = 1'b1; last_idx = 2'd3; end
          default: ;
        endcase
      end
    end
  end

  assign is_mem    = is_load | is_store;
  assign byte_addr = in_alu + {30'd0, cnt_q};
  assign wdata_sh  = in_rdata2 >> {cnt_q, 3'b000};

  // Buffer is zero-cleared on XFER entry, so only signed widths need work here.
  always_comb begin
    case (in_funct3)
      3'b000:  load_val = {{24{rbuf_q[7]}}, rbuf_q[7:0]};
      3'b001:  load_val = {{16{rbuf_q[15]}}, rbuf_q[15:0]};
      default: load_val = rbuf_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      StIdle: begin
        if (is_mem) begin
          state_d = StXfer;
          cnt_d   = 2'd0;
          rbuf_d  = 32'd0;
        end
      end
      StXfer: begin
        if (mc_ack) begin
          if (is_load) rbuf_d[8*cnt_q +: 8] = mc_rdata;
          if (cnt_q == last_idx) state_d = StDone;
          else                   cnt_d   = cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      rbuf_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Outputs are forced quiet while rst is held, whatever the inputs show.
  always_comb begin
    mc_req   = 1'b0;
    mc_we    = 1'b0;
    mc_addr  = '0;
    mc_wdata = 8'd0;
    wb_we    = 1'b0;
    wb_waddr = 5'd0;
    wb_wdata = 32'd0;
    stallreq = 1'b0;
    if (!rst) begin
      case (state_q)
        StIdle: begin
          wb_waddr = in_waddr;
          if (is_mem) begin
            stallreq = 1'b1;
          end else begin
            wb_we    = in_we & in_flag;
            wb_wdata = in_alu;
          end
        end
        StXfer: begin
          mc_req   = 1'b1;
          mc_we    = is_store;
          mc_addr  = ADDR_WIDTH'(byte_addr);
          mc_wdata = is_store ? wdata_sh[7:0] : 8'd0;
          stallreq = 1'b1;
          wb_waddr = in_waddr;
        end
        StDone: begin
          wb_waddr = in_waddr;
          if (is_load) begin
            wb_we    = in_we;
            wb_wdata = load_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-level memory responder plus a word-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_flag;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_we;
  logic [4:0]  in_waddr;
  logic [31:0] in_alu;
  logic [31:0] in_rdata2;
  logic        mc_req;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic        mc_ack;
  logic [7:0]  mc_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        stallreq;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_flag(in_flag), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_we(in_we), .in_waddr(in_waddr), .in_alu(in_alu), .in_rdata2(in_rdata2),
    .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_ack(mc_ack), .mc_rdata(mc_rdata), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .stallreq(stallreq)
  );

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPR   = 7'b0110011;

  int total = 0;
  int bad   = 0;
  int wait_n = 0;
  int wcnt   = 0;
  bit spur   = 1'b0;

  logic [7:0]  mem     [int];
  logic [7:0]  ref_mem [int];
  logic [31:0] log_addr[$];
  logic        log_we  [$];
  logic [7:0]  log_wd  [$];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  // Word-level load result from the reference memory.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    longint v = 0;
    for (int i = 0; i < nbytes(f3); i++) v += longint'(ref_byte(a + i)) << (8 * i);
    if (f3 == 3'b000 && v >= 128)   v -= 256;
    if (f3 == 3'b001 && v >= 32768) v -= 65536;
    return v[31:0];
  endfunction

  // Memory-controller responder: wait_n idle cycles, then a one-cycle ack.
  initial begin
    mc_ack   = 1'b0;
    mc_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mc_ack) begin
        mc_ack = 1'b0;
      end else if (spur) begin
        mc_ack   = 1'b1;
        mc_rdata = 8'hEE;
        spur     = 1'b0;
      end else if (mc_req) begin
        if (wcnt < wait_n) begin
          wcnt++;
        end else begin
          log_addr.push_back(mc_addr);
          log_we.push_back(mc_we);
          log_wd.push_back(mc_wdata);
          if (mc_we) mem[int'(mc_addr)] = mc_wdata;
          else       mc_rdata = mem_byte(mc_addr);
          mc_ack = 1'b1;
          wcnt   = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic drive_bubble();
    in_flag = 1'b0; in_opcode = 7'd0; in_funct3 = 3'd0; in_we = 1'b0;
    in_waddr = 5'd0; in_alu = 32'd0; in_rdata2 = 32'd0;
  endtask

  task automatic set_byte(input logic [31:0] a, input logic [7:0] b);
    mem[int'(a)]     = b;
    ref_mem[int'(a)] = b;
  endtask

  // Issues one memory op and runs it to DONE; returns what DONE presented.
  task automatic do_mem(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d2, input logic we, input logic [4:0] wa,
                        output logic o_we, output logic [4:0] o_wa, output logic [31:0] o_wd,
                        output bit timeout, output int stall_bad);
    log_addr.delete(); log_we.delete(); log_wd.delete();
    @(negedge clk);
    in_flag = 1'b1; in_opcode = op; in_funct3 = f3; in_we = we;
    in_waddr = wa; in_alu = a; in_rdata2 = d2;
    #1;
    stall_bad = (stallreq !== 1'b1 || mc_req !== 1'b0) ? 1 : 0;
    timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (stallreq === 1'b0) begin timeout = 1'b0; break; end
      if (wb_we !== 1'b0 || mc_req !== 1'b1) stall_bad++;
    end
    if (mc_req !== 1'b0) stall_bad++;
    o_we = wb_we; o_wa = wb_waddr; o_wd = wb_wdata;
    @(negedge clk);
    drive_bubble();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_flag = 1'b1; in_opcode = OPR; in_funct3 = 3'd0; in_we = 1'b1;
    in_waddr = 5'd9; in_alu = 32'h1234_5678; in_rdata2 = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if ({mc_req, mc_we, mc_addr, mc_wdata} !== 42'd0) begin
      bad++; $display("FAIL reset_mc: got req=%b we=%b addr=%h wd=%h want all 0",
                      mc_req, mc_we, mc_addr, mc_wdata);
    end
    total++;
    if ({stallreq, wb_we, wb_waddr, wb_wdata} !== 39'd0) begin
      bad++; $display("FAIL reset_wb: got stall=%b we=%b wa=%0d wd=%h want all 0",
                      stallreq, wb_we, wb_waddr, wb_wdata);
    end
    rst = 1'b0;
    drive_bubble();
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    in_flag = 1'b1; in_opcode = OPR; in_we = 1'b1; in_waddr = 5'd5; in_alu = 32'h2A;
    #1;
    total++;
    if ({wb_we, wb_waddr, wb_wdata, stallreq, mc_req} !== {1'b1, 5'd5, 32'h2A, 1'b0, 1'b0}) begin
      bad++; $display("FAIL add_pass: got we=%b wa=%0d wd=%h stall=%b req=%b want 1 5 2a 0 0",
                      wb_we, wb_waddr, wb_wdata, stallreq, mc_req);
    end
    @(negedge clk);
    in_flag = 1'b0; in_opcode = LOAD; in_funct3 = 3'b010; in_we = 1'b1; in_alu = 32'h1000;
    #1;
    total++;
    if ({mc_req, wb_we, stallreq} !== 3'b000) begin
      bad++; $display("FAIL bubble: got req=%b we=%b stall=%b want 000", mc_req, wb_we, stallreq);
    end
    @(negedge clk); #1;
    total++;
    if ({mc_req, stallreq} !== 2'b00) begin
      bad++; $display("FAIL bubble_next: got req=%b stall=%b want 00", mc_req, stallreq);
    end
    drive_bubble();
  endtask

  task automatic test_lb();
    logic o_we; logic [4:0] o_wa; logic [31:0] o_wd; bit to; int sb;
    set_byte(32'h1000, 8'h80);
    wait_n = 1;
    do_mem(LOAD, 3'b000, 32'h1000, 32'd0, 1'b1, 5'd7, o_we, o_wa, o_wd, to, sb);
    total++;
    if (to || sb != 0) begin
      bad++; $display("FAIL lb_handshake: got timeout=%0d stallerr=%0d want 0 0", to, sb);
    end
    total++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h1000 || log_we[0] !== 1'b0) begin
      bad++; $display("FAIL lb_req: got %0d reqs want 1 read at 00001000", log_addr.size());
    end
    total++;
    if ({o_we, o_wa, o_wd} !== {1'b1, 5'd7, 32'hFFFF_FF80}) begin
      bad++; $display("FAIL lb_data: got we=%b wa=%0d wd=%h want 1 7 ffffff80", o_we, o_wa, o_wd);
    end
    do_mem(LOAD, 3'b100, 32'h1000, 32'd0, 1'b1, 5'd7, o_we, o_wa, o_wd, to, sb);
    total++;
    if (to || o_wd !== 32'h0000_0080) begin
      bad++; $display("FAIL lbu_data: got wd=%h timeout=%0d want 00000080", o_wd, to);
    end
  endtask

  task automatic test_lw_wait();
    logic o_we; logic [4:0] o_wa; logic [31:0] o_wd; bit to; int sb; bit ord;
    set_byte(32'h2000, 8'h78); set_byte(32'h2001, 8'h56);
    set_byte(32'h2002, 8'h34); set_byte(32'h2003, 8'h12);
    wait_n = 2;
    do_mem(LOAD, 3'b010, 32'h2000, 32'd0, 1'b1, 5'd3, o_we, o_wa, o_wd, to, sb);
    ord = (log_addr.size() == 4);
    for (int i = 0; i < log_addr.size(); i++) if (log_addr[i] !== 32'h2000 + i) ord = 1'b0;
    total++;
    if (!ord) begin
      bad++; $display("FAIL lw_order: got %0d reqs, want 2000..2003 in order", log_addr.size());
    end
    total++;
    if (to || sb != 0) begin
      bad++; $display("FAIL lw_stall: got timeout=%0d stallerr=%0d want 0 0", to, sb);
    end
    total++;
    if (o_wd !== 32'h1234_5678 || o_we !== 1'b1) begin
      bad++; $display("FAIL lw_data: got we=%b wd=%h want 1 12345678", o_we, o_wd);
    end
  endtask

  task automatic test_sh();
    logic o_we; logic [4:0] o_wa; logic [31:0] o_wd; bit to; int sb;
    wait_n = 0;
    do_mem(STORE, 3'b001, 32'h3001, 32'hABCD_1234, 1'b1, 5'd2, o_we, o_wa, o_wd, to, sb);
    total++;
    if (log_addr.size() != 2) begin
      bad++; $display("FAIL sh_count: got %0d reqs want 2", log_addr.size());
    end else begin
      total++;
      if ({log_we[0], log_addr[0], log_wd[0], log_we[1], log_addr[1], log_wd[1]} !==
          {1'b1, 32'h3001, 8'h34, 1'b1, 32'h3002, 8'h12}) begin
        bad++; $display("FAIL sh_bytes: got %h@%h %h@%h want 34@3001 12@3002",
                        log_wd[0], log_addr[0], log_wd[1], log_addr[1]);
      end
    end
    total++;
    if (to || sb != 0 || o_we !== 1'b0 || o_wd !== 32'd0) begin
      bad++; $display("FAIL sh_done: got we=%b wd=%h timeout=%0d stallerr=%0d want 0 0 0 0",
                      o_we, o_wd, to, sb);
    end
  endtask

  task automatic test_reset_mid();
    logic o_we; logic [4:0] o_wa; logic [31:0] o_wd; bit to; int sb; bit seen;
    set_byte(32'h4000, 8'hFF); set_byte(32'h4001, 8'h7F);
    wait_n = 0;
    log_addr.delete(); log_we.delete(); log_wd.delete();
    @(negedge clk);
    in_flag = 1'b1; in_opcode = LOAD; in_funct3 = 3'b001; in_we = 1'b1;
    in_waddr = 5'd4; in_alu = 32'h4000;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (log_addr.size() >= 1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL rstmid_first_ack: got no request want 1");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({mc_req, stallreq, wb_we} !== 3'b000) begin
      bad++; $display("FAIL rstmid_idle: got req=%b stall=%b we=%b want 000",
                      mc_req, stallreq, wb_we);
    end
    rst = 1'b0;
    drive_bubble();
    spur = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({mc_req, stallreq} !== 2'b00) begin
      bad++; $display("FAIL rstmid_late_ack: got req=%b stall=%b want 00", mc_req, stallreq);
    end
    do_mem(LOAD, 3'b001, 32'h4000, 32'd0, 1'b1, 5'd4, o_we, o_wa, o_wd, to, sb);
    total++;
    if (to || o_wd !== 32'h0000_7FFF || log_addr.size() != 2) begin
      bad++; $display("FAIL rstmid_lh: got wd=%h reqs=%0d timeout=%0d want 00007fff 2 0",
                      o_wd, log_addr.size(), to);
    end
  endtask

  task automatic test_random();
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    logic o_we; logic [4:0] o_wa; logic [31:0] o_wd; bit to; int sb; bit ok;
    logic [31:0] a, d2, alu; logic we; logic [4:0] wa; int k; logic [2:0] f3; int n;
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100;
    ld_f3[4] = 3'b101;
    st_f3[0] = 3'b000; st_f3[1] = 3'b001; st_f3[2] = 3'b010;
    for (int i = 0; i < 72; i++) set_byte(32'h5000 + i, 8'($urandom));
    for (int it = 0; it < 40; it++) begin
      k      = $urandom_range(0, 9);
      a      = 32'h5000 + $urandom_range(0, 64);
      d2     = $urandom;
      we     = 1'($urandom);
      wa     = 5'($urandom);
      wait_n = $urandom_range(0, 3);
      if (k <= 4) begin
        f3 = ld_f3[k];
        do_mem(LOAD, f3, a, d2, we, wa, o_we, o_wa, o_wd, to, sb);
        ok = !to && sb == 0 && log_addr.size() == nbytes(f3);
        for (int j = 0; j < log_addr.size(); j++) if (log_addr[j] !== a + j) ok = 1'b0;
        total++;
        if (!ok || {o_we, o_wa, o_wd} !== {we, wa, exp_load(f3, a)}) begin
          bad++; $display("FAIL rand_load f3=%b a=%h: got we=%b wa=%0d wd=%h reqs=%0d want %b %0d %h %0d",
                          f3, a, o_we, o_wa, o_wd, log_addr.size(), we, wa, exp_load(f3, a),
                          nbytes(f3));
        end
      end else if (k <= 7) begin
        f3 = st_f3[k - 5];
        n  = nbytes(f3);
        do_mem(STORE, f3, a, d2, we, wa, o_we, o_wa, o_wd, to, sb);
        for (int j = 0; j < n; j++) ref_mem[int'(a + j)] = d2[8*j +: 8];
        ok = !to && sb == 0 && log_addr.size() == n && o_we === 1'b0 && o_wd === 32'd0;
        for (int j = 0; j < n; j++) if (mem_byte(a + j) !== ref_byte(a + j)) ok = 1'b0;
        for (int j = 0; j < log_addr.size(); j++) if (log_addr[j] !== a + j) ok = 1'b0;
        total++;
        if (!ok) begin
          bad++; $display("FAIL rand_store f3=%b a=%h d=%h: got reqs=%0d we=%b wd=%h want %0d 0 0",
                          f3, a, d2, log_addr.size(), o_we, o_wd, n);
        end
      end else begin
        alu = $urandom;
        @(negedge clk);
        in_flag = (k == 8); in_we = we; in_waddr = wa; in_alu = alu; in_rdata2 = d2;
        case ($urandom_range(0, 2))
          0:       begin in_opcode = OPR;   in_funct3 = 3'($urandom); end
          1:       begin in_opcode = LOAD;  in_funct3 = (k == 8) ? 3'b011 : 3'b010; end
          default: begin in_opcode = STORE; in_funct3 = (k == 8) ? 3'b100 : 3'b000; end
        endcase
        #1;
        total++;
        if ({wb_we, wb_waddr, wb_wdata, stallreq, mc_req} !==
            {we & (k == 8), wa, alu, 1'b0, 1'b0}) begin
          bad++; $display("FAIL rand_pass: got we=%b wa=%0d wd=%h stall=%b req=%b want %b %0d %h 0 0",
                          wb_we, wb_waddr, wb_wdata, stallreq, mc_req, we & (k == 8), wa, alu);
        end
        @(negedge clk);
        drive_bubble();
      end
    end
  endtask

  initial begin
    drive_bubble();
    test_reset();
    test_passthrough();
    test_lb();
    test_lw_wait();
    test_sh();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
